// File: rtl/branch_rs.sv
`default_nettype none
// ============================================================================
// branch_rs : in-order reservation station for branch/jump uops, with CDB
//             operand capture and oldest-first issue to the branch unit.
// Revision  : 1.0  initial release
// ============================================================================
module branch_rs #(
    parameter int ROB_TAG_W = 4,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   disp_valid_i,
    output logic                   disp_ready_o,
    input  logic [31:0]            disp_pc_i,
    input  logic [31:0]            disp_imm_i,
    input  logic                   disp_is_branch_i,
    input  logic                   disp_is_jump_i,
    input  logic                   disp_pred_taken_i,
    input  logic [ROB_TAG_W-1:0]   disp_rob_tag_i,
    input  logic                   disp_rs1_rdy_i,
    input  logic                   disp_rs2_rdy_i,
    input  logic [31:0]            disp_rs1_val_i,
    input  logic [31:0]            disp_rs2_val_i,
    input  logic [ROB_TAG_W-1:0]   disp_rs1_tag_i,
    input  logic [ROB_TAG_W-1:0]   disp_rs2_tag_i,
    input  logic                   cdb_valid_i,
    input  logic [ROB_TAG_W-1:0]   cdb_tag_i,
    input  logic [31:0]            cdb_val_i,
    output logic                   iss_valid_o,
    output logic [31:0]            iss_pc_o,
    output logic [31:0]            iss_imm_o,
    output logic [31:0]            iss_rs1_val_o,
    output logic [31:0]            iss_rs2_val_o,
    output logic                   iss_is_branch_o,
    output logic                   iss_is_jump_o,
    output logic                   iss_pred_taken_o,
    output logic [ROB_TAG_W-1:0]   iss_rob_tag_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     is_br_q;
    logic [DEPTH-1:0]     is_jmp_q;
    logic [DEPTH-1:0]     pred_q;
    logic [DEPTH-1:0]     rs1_rdy_q;
    logic [DEPTH-1:0]     rs2_rdy_q;
    logic [31:0]          pc_q      [DEPTH];
    logic [31:0]          imm_q     [DEPTH];
    logic [31:0]          rs1_val_q [DEPTH];
    logic [31:0]          rs2_val_q [DEPTH];
    logic [ROB_TAG_W-1:0] rob_q     [DEPTH];
    logic [ROB_TAG_W-1:0] rs1_tag_q [DEPTH];
    logic [ROB_TAG_W-1:0] rs2_tag_q [DEPTH];

    logic [c_ptr_w-1:0] head_q, head_d;
    logic [c_ptr_w-1:0] tail_q, tail_d;
    logic [c_cnt_w-1:0] count_q, count_d;

    logic w_disp;
    logic w_iss;
    logic w_rs1_cap;
    logic w_rs2_cap;

    assign disp_ready_o = (count_q < c_cnt_w'(DEPTH));
    assign count_o      = count_q;

    assign w_disp = disp_valid_i && disp_ready_o && !flush_i;
    // Eligibility uses stored rdy bits only, so a same-cycle wakeup issues next cycle.
    assign w_iss  = valid_q[head_q] && rs1_rdy_q[head_q] && rs2_rdy_q[head_q] && !flush_i;

    assign w_rs1_cap = !disp_rs1_rdy_i && cdb_valid_i && (cdb_tag_i == disp_rs1_tag_i);
    assign w_rs2_cap = !disp_rs2_rdy_i && cdb_valid_i && (cdb_tag_i == disp_rs2_tag_i);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_iss) begin
            head_d = head_q + c_ptr_w'(1);
        end
        if (w_disp) begin
            tail_d = tail_q + c_ptr_w'(1);
        end
        case ({w_disp, w_iss})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q          <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            iss_valid_o      <= 1'b0;
            iss_pc_o         <= '0;
            iss_imm_o        <= '0;
            iss_rs1_val_o    <= '0;
            iss_rs2_val_o    <= '0;
            iss_is_branch_o  <= 1'b0;
            iss_is_jump_o    <= 1'b0;
            iss_pred_taken_o <= 1'b0;
            iss_rob_tag_o    <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            iss_valid_o <= w_iss;
            if (w_iss) begin
                iss_pc_o         <= pc_q[head_q];
                iss_imm_o        <= imm_q[head_q];
                iss_rs1_val_o    <= rs1_val_q[head_q];
                iss_rs2_val_o    <= rs2_val_q[head_q];
                iss_is_branch_o  <= is_br_q[head_q];
                iss_is_jump_o    <= is_jmp_q[head_q];
                iss_pred_taken_o <= pred_q[head_q];
                iss_rob_tag_o    <= rob_q[head_q];
            end
            if (flush_i) begin
                valid_q <= '0;
            end else begin
                // Tail and head never coincide here: dispatch needs room, issue needs an entry.
                if (w_iss) begin
                    valid_q[head_q] <= 1'b0;
                end
                if (w_disp) begin
                    valid_q[tail_q] <= 1'b1;
                end
            end
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && cdb_valid_i) begin
                if (!rs1_rdy_q[i] && (rs1_tag_q[i] == cdb_tag_i)) begin
                    rs1_rdy_q[i] <= 1'b1;
                    rs1_val_q[i] <= cdb_val_i;
                end
                if (!rs2_rdy_q[i] && (rs2_tag_q[i] == cdb_tag_i)) begin
                    rs2_rdy_q[i] <= 1'b1;
                    rs2_val_q[i] <= cdb_val_i;
                end
            end
        end
        if (w_disp) begin
            pc_q[tail_q]      <= disp_pc_i;
            imm_q[tail_q]     <= disp_imm_i;
            is_br_q[tail_q]   <= disp_is_branch_i;
            is_jmp_q[tail_q]  <= disp_is_jump_i;
            pred_q[tail_q]    <= disp_pred_taken_i;
            rob_q[tail_q]     <= disp_rob_tag_i;
            rs1_tag_q[tail_q] <= disp_rs1_tag_i;
            rs2_tag_q[tail_q] <= disp_rs2_tag_i;
            rs1_rdy_q[tail_q] <= disp_rs1_rdy_i || w_rs1_cap;
            rs2_rdy_q[tail_q] <= disp_rs2_rdy_i || w_rs2_cap;
            rs1_val_q[tail_q] <= disp_rs1_rdy_i ? disp_rs1_val_i : cdb_val_i;
            rs2_val_q[tail_q] <= disp_rs2_rdy_i ? disp_rs2_val_i : cdb_val_i;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_rs.sv
`default_nettype none
// ============================================================================
// tb_branch_rs : directed + randomized bench for branch_rs against a queue model.
// Revision     : 1.0  initial release
// ============================================================================
module tb_branch_rs;
    localparam int ROB_TAG_W = 4;
    localparam int DEPTH     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        disp_valid_i = 1'b0;
    logic        disp_ready_o;
    logic [31:0] disp_pc_i = '0, disp_imm_i = '0;
    logic        disp_is_branch_i = 1'b0, disp_is_jump_i = 1'b0, disp_pred_taken_i = 1'b0;
    logic [3:0]  disp_rob_tag_i = '0;
    logic        disp_rs1_rdy_i = 1'b0, disp_rs2_rdy_i = 1'b0;
    logic [31:0] disp_rs1_val_i = '0, disp_rs2_val_i = '0;
    logic [3:0]  disp_rs1_tag_i = '0, disp_rs2_tag_i = '0;
    logic        cdb_valid_i = 1'b0;
    logic [3:0]  cdb_tag_i = '0;
    logic [31:0] cdb_val_i = '0;
    logic        iss_valid_o;
    logic [31:0] iss_pc_o, iss_imm_o, iss_rs1_val_o, iss_rs2_val_o;
    logic        iss_is_branch_o, iss_is_jump_o, iss_pred_taken_o;
    logic [3:0]  iss_rob_tag_o;
    logic [2:0]  count_o;

    branch_rs #(.ROB_TAG_W(ROB_TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_pc_i(disp_pc_i), .disp_imm_i(disp_imm_i),
        .disp_is_branch_i(disp_is_branch_i), .disp_is_jump_i(disp_is_jump_i),
        .disp_pred_taken_i(disp_pred_taken_i), .disp_rob_tag_i(disp_rob_tag_i),
        .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs2_rdy_i(disp_rs2_rdy_i),
        .disp_rs1_val_i(disp_rs1_val_i), .disp_rs2_val_i(disp_rs2_val_i),
        .disp_rs1_tag_i(disp_rs1_tag_i), .disp_rs2_tag_i(disp_rs2_tag_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_val_i(cdb_val_i),
        .iss_valid_o(iss_valid_o), .iss_pc_o(iss_pc_o), .iss_imm_o(iss_imm_o),
        .iss_rs1_val_o(iss_rs1_val_o), .iss_rs2_val_o(iss_rs2_val_o),
        .iss_is_branch_o(iss_is_branch_o), .iss_is_jump_o(iss_is_jump_o),
        .iss_pred_taken_o(iss_pred_taken_o), .iss_rob_tag_o(iss_rob_tag_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, imm;
        logic        br, jmp, pt;
        logic [3:0]  rob;
        logic        r1, r2;
        logic [31:0] v1, v2;
        logic [3:0]  t1, t2;
    } ent_t;

    ent_t mq[$];
    ent_t exp_out;
    logic exp_valid;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the station is a program-ordered queue of entries.
    always @(posedge clk) begin
        ent_t e;
        bit   iss;
        bit   acc;
        if (rst) begin
            mq.delete();
            exp_valid = 1'b0;
            exp_out   = '{default: 0};
        end else if (flush_i) begin
            mq.delete();
            exp_valid = 1'b0;
        end else begin
            iss = (mq.size() > 0) && mq[0].r1 && mq[0].r2;
            acc = disp_valid_i && (mq.size() < DEPTH);
            if (cdb_valid_i) begin
                foreach (mq[i]) begin
                    if (!mq[i].r1 && mq[i].t1 == cdb_tag_i) begin mq[i].r1 = 1'b1; mq[i].v1 = cdb_val_i; end
                    if (!mq[i].r2 && mq[i].t2 == cdb_tag_i) begin mq[i].r2 = 1'b1; mq[i].v2 = cdb_val_i; end
                end
            end
            exp_valid = iss;
            if (iss) exp_out = mq.pop_front();
            if (acc) begin
                e.pc = disp_pc_i; e.imm = disp_imm_i; e.br = disp_is_branch_i;
                e.jmp = disp_is_jump_i; e.pt = disp_pred_taken_i; e.rob = disp_rob_tag_i;
                e.t1 = disp_rs1_tag_i; e.t2 = disp_rs2_tag_i;
                e.r1 = disp_rs1_rdy_i || (cdb_valid_i && cdb_tag_i == disp_rs1_tag_i);
                e.r2 = disp_rs2_rdy_i || (cdb_valid_i && cdb_tag_i == disp_rs2_tag_i);
                e.v1 = disp_rs1_rdy_i ? disp_rs1_val_i : cdb_val_i;
                e.v2 = disp_rs2_rdy_i ? disp_rs2_val_i : cdb_val_i;
                mq.push_back(e);
            end
        end
        #1;
        check("m_iss_valid", iss_valid_o, exp_valid);
        check("m_pc", iss_pc_o, exp_out.pc);
        check("m_imm", iss_imm_o, exp_out.imm);
        check("m_rs1", iss_rs1_val_o, exp_out.v1);
        check("m_rs2", iss_rs2_val_o, exp_out.v2);
        check("m_kind", {iss_is_branch_o, iss_is_jump_o, iss_pred_taken_o},
              {exp_out.br, exp_out.jmp, exp_out.pt});
        check("m_rob", iss_rob_tag_o, exp_out.rob);
        check("m_count", count_o, mq.size());
        check("m_ready", disp_ready_o, mq.size() < DEPTH);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid_i = 1'b0;
        cdb_valid_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic disp(input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] rob,
                        input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [3:0] t2);
        disp_valid_i = 1'b1; disp_pc_i = pc; disp_imm_i = imm; disp_rob_tag_i = rob;
        disp_is_branch_i = 1'b1; disp_is_jump_i = 1'b0; disp_pred_taken_i = 1'b0;
        disp_rs1_rdy_i = r1; disp_rs1_val_i = v1; disp_rs1_tag_i = t1;
        disp_rs2_rdy_i = r2; disp_rs2_val_i = v2; disp_rs2_tag_i = t2;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        cdb_valid_i = 1'b1; cdb_tag_i = t; cdb_val_i = v;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) step();
        check("rst_iss_valid", iss_valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_ready", disp_ready_o, 1);
        check("rst_pc", iss_pc_o, 0);
        rst = 1'b0;

        // Ready BNE: two-cycle dispatch-to-issue latency.
        disp(32'h100, 32'h20, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        step(); idle();
        check("t1_count1", count_o, 1);
        step();
        check("t1_valid", iss_valid_o, 1);
        check("t1_pc", iss_pc_o, 32'h100);
        check("t1_imm", iss_imm_o, 32'h20);
        check("t1_rob", iss_rob_tag_o, 3);
        check("t1_rs1", iss_rs1_val_o, 5);
        check("t1_rs2", iss_rs2_val_o, 7);
        check("t1_count0", count_o, 0);
        step();
        check("t1_pulse", iss_valid_o, 0);

        // Late CDB wakeup of rs2, then same-cycle capture at dispatch.
        disp(32'h200, 32'h8, 4'd4, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9);
        step(); idle();
        step(); step();
        cdb(4'd9, 32'h55);
        step(); idle();
        check("t2_wait", iss_valid_o, 0);
        step();
        check("t2_valid", iss_valid_o, 1);
        check("t2_rs2", iss_rs2_val_o, 32'h55);
        check("t2_rob", iss_rob_tag_o, 4);
        step();
        disp(32'h300, 32'h4, 4'd5, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0, 4'd9);
        cdb(4'd9, 32'h55);
        step(); idle();
        step();
        check("t2b_valid", iss_valid_o, 1);
        check("t2b_rs2", iss_rs2_val_o, 32'h55);
        check("t2b_rob", iss_rob_tag_o, 5);
        step();

        // Ready younger entry waits behind a blocked head.
        disp(32'h400, 32'h0, 4'd10, 1'b0, 32'd0, 4'd2, 1'b1, 32'd3, 4'd0);
        step();
        disp(32'h404, 32'h0, 4'd11, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        step(); idle();
        repeat (3) begin
            step();
            check("t3_blocked", iss_valid_o, 0);
        end
        check("t3_count", count_o, 2);
        cdb(4'd2, 32'h77);
        step(); idle();
        check("t3_w", iss_valid_o, 0);
        step();
        check("t3_first", {iss_valid_o, iss_rob_tag_o}, {1'b1, 4'd10});
        check("t3_rs1", iss_rs1_val_o, 32'h77);
        step();
        check("t3_second", {iss_valid_o, iss_rob_tag_o}, {1'b1, 4'd11});
        step();

        // Fill to DEPTH, refuse a fifth, then drain in order.
        for (int i = 0; i < 4; i++) begin
            disp(32'h500 + 32'(4 * i), 32'h0, 4'(i), (i != 0), 32'd0, 4'hE, 1'b1, 32'd2, 4'd0);
            step();
        end
        check("t4_full_count", count_o, 4);
        check("t4_full_ready", disp_ready_o, 0);
        disp(32'h600, 32'h0, 4'd7, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        step(); idle();
        check("t4_reject", count_o, 4);
        cdb(4'hE, 32'h99);
        step(); idle();
        check("t4_w", iss_valid_o, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_order", {iss_valid_o, iss_rob_tag_o}, {1'b1, 4'(i)});
        end
        step();
        check("t4_empty", count_o, 0);

        // Flush with three held entries and a concurrent matching broadcast.
        for (int i = 0; i < 3; i++) begin
            disp(32'h700 + 32'(4 * i), 32'h0, 4'(12 + i), 1'b0, 32'd0, 4'hA, 1'b1, 32'd0, 4'd0);
            step();
        end
        idle();
        flush_i = 1'b1;
        cdb(4'hA, 32'h1);
        step(); idle();
        check("t5_count", count_o, 0);
        check("t5_ready", disp_ready_o, 1);
        check("t5_tail", dut.tail_q, 0);
        check("t5_noiss", iss_valid_o, 0);
        step();
        check("t5_noiss2", iss_valid_o, 0);
        disp(32'h780, 32'h0, 4'd13, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        step(); idle();
        check("t5_slot0", dut.valid_q, 4'b0001);
        step();
        check("t5_after", {iss_valid_o, iss_rob_tag_o}, {1'b1, 4'd13});
        step();

        // Simultaneous dispatch and issue at count=2.
        disp(32'h800, 32'h0, 4'd8, 1'b0, 32'd0, 4'hB, 1'b1, 32'd0, 4'd0);
        step();
        disp(32'h804, 32'h0, 4'd9, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        step(); idle();
        cdb(4'hB, 32'h5);
        step(); idle();
        check("t6_pre", count_o, 2);
        disp(32'h808, 32'h0, 4'd1, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        step(); idle();
        check("t6_count", count_o, 2);
        check("t6_iss0", {iss_valid_o, iss_rob_tag_o}, {1'b1, 4'd8});
        step();
        check("t6_iss1", {iss_valid_o, iss_rob_tag_o}, {1'b1, 4'd9});
        step();
        check("t6_iss2", {iss_valid_o, iss_rob_tag_o}, {1'b1, 4'd1});
        check("t6_empty", count_o, 0);

        // Randomized traffic; the model checks every cycle.
        repeat (4000) begin
            disp_valid_i      = ($urandom % 2) == 0;
            disp_pc_i         = $urandom;
            disp_imm_i        = $urandom;
            disp_is_branch_i  = $urandom % 2;
            disp_is_jump_i    = $urandom % 2;
            disp_pred_taken_i = $urandom % 2;
            disp_rob_tag_i    = 4'($urandom);
            disp_rs1_rdy_i    = $urandom % 2;
            disp_rs2_rdy_i    = $urandom % 2;
            disp_rs1_val_i    = $urandom;
            disp_rs2_val_i    = $urandom;
            disp_rs1_tag_i    = 4'($urandom_range(0, 7));
            disp_rs2_tag_i    = 4'($urandom_range(0, 7));
            cdb_valid_i       = ($urandom % 3) == 0;
            cdb_tag_i         = 4'($urandom_range(0, 7));
            cdb_val_i         = $urandom;
            flush_i           = ($urandom % 80) == 0;
            step();
        end
        idle();
        repeat (20) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
